scs8hd_q_deser: RTL and testbench

//   Serial-to-parallel frame deserializer sitting directly downstream of a scs8hd_dfxtp flop chain.

---
 rtl/scs8hd_deser_pkg.sv | 14 +
 rtl/scs8hd_q_deser_if.sv | 16 +
 rtl/scs8hd_deser_shreg.sv | 30 +++
 rtl/scs8hd_q_deser.sv | 132 +++++++++++++
 tb/tb_scs8hd_q_deser.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/scs8hd_deser_pkg.sv
// Shared constants for the Q-output frame deserializer: FSM state
// encodings and the default word geometry.
package scs8hd_deser_pkg;

    localparam logic [1:0] ST_HUNT  = 2'd0;
    localparam logic [1:0] ST_DATA  = 2'd1;
    localparam logic [1:0] ST_CHECK = 2'd2;

    localparam int               DEF_WIDTH         = 8;
    localparam logic [7:0]       DEF_SYNC_WORD     = 8'hB8;
    localparam int               DEF_FRAME_WORDS   = 4;
    localparam int               DEF_SYNC_LOSS_MAX = 3;

endpackage

// File: rtl/scs8hd_q_deser_if.sv
// Word output channel of the deserializer.
// Handshake: the producer raises WORD_VALID with WORD and holds both stable
// until a CLK edge where WORD_VALID & WORD_READY are both 1; that edge is the
// transfer. WORD_READY may be high while WORD_VALID is low and means nothing then.
interface scs8hd_q_deser_if
    import scs8hd_deser_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic [WIDTH-1:0] WORD;
    logic             WORD_VALID;
    logic             WORD_READY;

    modport master (output WORD, output WORD_VALID, input WORD_READY);
    modport slave  (input WORD, input WORD_VALID, output WORD_READY);
endinterface

// File: rtl/scs8hd_deser_shreg.sv
// Serial shift register fed from the upstream flop Q, with a comparator
// that looks at the value the register will hold after the current bit.
module scs8hd_deser_shreg
    import scs8hd_deser_pkg::*;
#(
    parameter int               WIDTH     = DEF_WIDTH,
    parameter logic [WIDTH-1:0] SYNC_WORD = DEF_SYNC_WORD
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             EN,
    input  logic             D,
    output logic [WIDTH-1:0] sh_next,
    output logic             sync_hit
);
    logic [WIDTH-1:0] sh_q;

    // New bit enters at the LSB, so the first received bit ends up at the MSB.
    assign sh_next  = {sh_q[WIDTH-2:0], D};
    assign sync_hit = (sh_next == SYNC_WORD);

    // Shift only on qualified cycles; reset clears any partial word.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            sh_q <= '0;
        end else if (EN) begin
            sh_q <= sh_next;
        end
    end
endmodule

// File: rtl/scs8hd_q_deser.sv
// Frame deserializer: hunts for the sync word, emits framed data words over
// a single-entry valid/ready output register, and rechecks sync every frame
// with a flywheel that tolerates up to SYNC_LOSS_MAX-1 consecutive misses.
module scs8hd_q_deser
    import scs8hd_deser_pkg::*;
#(
    parameter int               WIDTH         = DEF_WIDTH,
    parameter logic [WIDTH-1:0] SYNC_WORD     = DEF_SYNC_WORD,
    parameter int               FRAME_WORDS   = DEF_FRAME_WORDS,
    parameter int               SYNC_LOSS_MAX = DEF_SYNC_LOSS_MAX
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     EN,
    input  logic                     D,
    scs8hd_q_deser_if.master         out_if,
    output logic                     LOCK,
    output logic                     OVERFLOW,
    output logic [1:0]               DBG_STATE
);
    localparam int BW = $clog2(WIDTH);
    localparam int WW = $clog2(FRAME_WORDS + 1);
    localparam int MW = $clog2(SYNC_LOSS_MAX + 1);

    logic [1:0]       state;
    logic [BW-1:0]    bit_cnt;
    logic [WW-1:0]    word_cnt;
    logic [MW-1:0]    miss_cnt;
    logic [WIDTH-1:0] sh_next;
    logic             sync_hit;
    logic             bit_last;
    logic             word_done;
    logic [WIDTH-1:0] word_q;
    logic             valid_q;

    scs8hd_deser_shreg #(
        .WIDTH     (WIDTH),
        .SYNC_WORD (SYNC_WORD)
    ) u_shreg (
        .CLK      (CLK),
        .RESET    (RESET),
        .EN       (EN),
        .D        (D),
        .sh_next  (sh_next),
        .sync_hit (sync_hit)
    );

    assign bit_last  = (bit_cnt == BW'(WIDTH - 1));
    assign word_done = EN && (state == ST_DATA) && bit_last;

    assign LOCK              = (state == ST_DATA) || (state == ST_CHECK);
    assign DBG_STATE         = state;
    assign out_if.WORD       = word_q;
    assign out_if.WORD_VALID = valid_q;

    // Framing FSM and its bit/word/miss counters; everything advances on EN only.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state    <= ST_HUNT;
            bit_cnt  <= '0;
            word_cnt <= '0;
            miss_cnt <= '0;
        end else if (EN) begin
            case (state)
                ST_HUNT: begin
                    if (sync_hit) begin
                        state    <= ST_DATA;
                        bit_cnt  <= '0;
                        word_cnt <= '0;
                        miss_cnt <= '0;
                    end
                end
                ST_DATA: begin
                    if (bit_last) begin
                        bit_cnt <= '0;
                        if (word_cnt == WW'(FRAME_WORDS - 1)) begin
                            word_cnt <= '0;
                            state    <= ST_CHECK;
                        end else begin
                            word_cnt <= word_cnt + 1'b1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                ST_CHECK: begin
                    if (bit_last) begin
                        bit_cnt <= '0;
                        if (sync_hit) begin
                            miss_cnt <= '0;
                            state    <= ST_DATA;
                        end else if (miss_cnt == MW'(SYNC_LOSS_MAX - 1)) begin
                            // Shift register keeps its content so HUNT can match on the next bit.
                            miss_cnt <= '0;
                            state    <= ST_HUNT;
                        end else begin
                            miss_cnt <= miss_cnt + 1'b1;
                            state    <= ST_DATA;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= ST_HUNT;
                    bit_cnt  <= '0;
                    word_cnt <= '0;
                    miss_cnt <= '0;
                end
            endcase
        end
    end

    // Single-entry output register: a completed word loads if the slot is free
    // or is being drained this cycle, otherwise it is dropped and flagged.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            word_q   <= '0;
            valid_q  <= 1'b0;
            OVERFLOW <= 1'b0;
        end else if (word_done) begin
            if (!valid_q || out_if.WORD_READY) begin
                word_q  <= sh_next;
                valid_q <= 1'b1;
            end else begin
                OVERFLOW <= 1'b1;
            end
        end else if (valid_q && out_if.WORD_READY) begin
            valid_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_scs8hd_q_deser.sv
// Directed bench for the frame deserializer: reset, framing, EN gating,
// overflow/handshake, flywheel loss and recovery.
module tb_scs8hd_q_deser;
    import scs8hd_deser_pkg::*;

    logic       CLK;
    logic       RESET;
    logic       EN;
    logic       D;
    logic       LOCK;
    logic       OVERFLOW;
    logic [1:0] DBG_STATE;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    scs8hd_q_deser_if #(.WIDTH(8)) dut_if ();

    scs8hd_q_deser dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .EN        (EN),
        .D         (D),
        .out_if    (dut_if),
        .LOCK      (LOCK),
        .OVERFLOW  (OVERFLOW),
        .DBG_STATE (DBG_STATE)
    );

    // clock / watchdog
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // scoreboard: every transfer must match the next expected word
    always @(negedge CLK) begin
        if (dut_if.WORD_VALID === 1'b1 && dut_if.WORD_READY === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL word_unexpected got %h required none", dut_if.WORD);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (dut_if.WORD !== e) begin
                    errors++;
                    $display("FAIL word_order got %h required %h", dut_if.WORD, e);
                end
            end
        end
    end

    // driver tasks
    task automatic drive_bit(input logic b, input logic en);
        D  = b;
        EN = en;
        @(posedge CLK);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] v, input logic toggle);
        for (int i = 7; i >= 0; i--) begin
            drive_bit(v[i], 1'b1);
            if (toggle) drive_bit(1'b0, 1'b0);
        end
    endtask

    task automatic send_frame(input logic [7:0] base);
        logic [7:0] w;
        for (int k = 0; k < 4; k++) begin
            w = base + 8'(k);
            exp_q.push_back(w);
            send_byte(w, 1'b0);
        end
    endtask

    task automatic do_reset(input int n);
        RESET = 1'b1;
        repeat (n) drive_bit(1'b0, 1'b0);
        RESET = 1'b0;
    endtask

    task automatic test_reset;
        dut_if.WORD_READY = 1'b1;
        RESET = 1'b1;
        drive_bit(1'b1, 1'b1);
        drive_bit(1'b1, 1'b1);
        checks++;
        if (dut_if.WORD !== 8'h00) begin errors++; $display("FAIL reset_word got %h required 00", dut_if.WORD); end
        checks++;
        if (dut_if.WORD_VALID !== 1'b0) begin errors++; $display("FAIL reset_valid got %b required 0", dut_if.WORD_VALID); end
        checks++;
        if (LOCK !== 1'b0) begin errors++; $display("FAIL reset_lock got %b required 0", LOCK); end
        checks++;
        if (OVERFLOW !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b required 0", OVERFLOW); end
        checks++;
        if (DBG_STATE !== ST_HUNT) begin errors++; $display("FAIL reset_state got %0d required %0d", DBG_STATE, ST_HUNT); end
        RESET = 1'b0;
    endtask

    task automatic test_reset_mid_word;
        do_reset(1);
        send_byte(8'hB8, 1'b0);
        checks++;
        if (LOCK !== 1'b1) begin errors++; $display("FAIL midreset_prelock got %b required 1", LOCK); end
        drive_bit(1'b1, 1'b1);
        drive_bit(1'b0, 1'b1);
        drive_bit(1'b1, 1'b1);
        RESET = 1'b1;
        drive_bit(1'b1, 1'b1);
        RESET = 1'b0;
        checks++;
        if (LOCK !== 1'b0) begin errors++; $display("FAIL midreset_lock got %b required 0", LOCK); end
        checks++;
        if (dut_if.WORD_VALID !== 1'b0 || dut_if.WORD !== 8'h00 || OVERFLOW !== 1'b0) begin
            errors++;
            $display("FAIL midreset_outputs got v=%b w=%h o=%b required 0/00/0", dut_if.WORD_VALID, dut_if.WORD, OVERFLOW);
        end
        send_byte(8'hB8, 1'b0);
        exp_q.push_back(8'h11);
        send_byte(8'h11, 1'b0);
        checks++;
        if (dut_if.WORD_VALID !== 1'b1 || dut_if.WORD !== 8'h11) begin
            errors++;
            $display("FAIL midreset_word got v=%b w=%h required 1/11", dut_if.WORD_VALID, dut_if.WORD);
        end
        drive_bit(1'b0, 1'b0);
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL midreset_drain got %0d left required 0", exp_q.size()); end
    endtask

    task automatic test_stream;
        logic [7:0] s;
        logic [7:0] w;
        dut_if.WORD_READY = 1'b1;
        do_reset(2);
        s = 8'hB8;
        for (int i = 7; i >= 0; i--) begin
            drive_bit(s[i], 1'b1);
            if (i == 1) begin
                checks++;
                if (LOCK !== 1'b0) begin errors++; $display("FAIL stream_lock_early got %b required 0", LOCK); end
            end
        end
        checks++;
        if (LOCK !== 1'b1) begin errors++; $display("FAIL stream_lock got %b required 1", LOCK); end
        for (int k = 1; k <= 4; k++) begin
            w = 8'(8'h11 * k);
            exp_q.push_back(w);
            for (int i = 7; i >= 0; i--) begin
                drive_bit(w[i], 1'b1);
                checks++;
                if (dut_if.WORD_VALID !== (i == 0)) begin
                    errors++;
                    $display("FAIL stream_valid word %h bit %0d got %b required %b", w, i, dut_if.WORD_VALID, (i == 0));
                end
                if (i == 0) begin
                    checks++;
                    if (dut_if.WORD !== w) begin errors++; $display("FAIL stream_word got %h required %h", dut_if.WORD, w); end
                end
            end
        end
        drive_bit(1'b0, 1'b0);
        checks++;
        if (OVERFLOW !== 1'b0) begin errors++; $display("FAIL stream_overflow got %b required 0", OVERFLOW); end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL stream_drain got %0d left required 0", exp_q.size()); end
    endtask

    task automatic test_en_toggle;
        dut_if.WORD_READY = 1'b1;
        do_reset(1);
        send_byte(8'hB8, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            exp_q.push_back(8'(8'h11 * k));
            send_byte(8'(8'h11 * k), 1'b1);
        end
        drive_bit(1'b0, 1'b0);
        drive_bit(1'b0, 1'b0);
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL toggle_drain got %0d left required 0", exp_q.size()); end
        checks++;
        if (LOCK !== 1'b1 || OVERFLOW !== 1'b0) begin
            errors++;
            $display("FAIL toggle_flags got lock=%b ovf=%b required 1/0", LOCK, OVERFLOW);
        end
    endtask

    task automatic test_overflow;
        logic [7:0] w;
        dut_if.WORD_READY = 1'b0;
        do_reset(1);
        send_byte(8'hB8, 1'b0);
        exp_q.push_back(8'h11);
        send_byte(8'h11, 1'b0);
        checks++;
        if (dut_if.WORD_VALID !== 1'b1 || dut_if.WORD !== 8'h11 || OVERFLOW !== 1'b0) begin
            errors++;
            $display("FAIL ovf_first got v=%b w=%h o=%b required 1/11/0", dut_if.WORD_VALID, dut_if.WORD, OVERFLOW);
        end
        send_byte(8'h22, 1'b0);
        checks++;
        if (dut_if.WORD_VALID !== 1'b1 || dut_if.WORD !== 8'h11) begin
            errors++;
            $display("FAIL ovf_hold got v=%b w=%h required 1/11", dut_if.WORD_VALID, dut_if.WORD);
        end
        checks++;
        if (OVERFLOW !== 1'b1) begin errors++; $display("FAIL ovf_set got %b required 1", OVERFLOW); end
        w = 8'h33;
        exp_q.push_back(w);
        for (int i = 7; i >= 1; i--) drive_bit(w[i], 1'b1);
        dut_if.WORD_READY = 1'b1;
        drive_bit(w[0], 1'b1);
        checks++;
        if (dut_if.WORD_VALID !== 1'b1 || dut_if.WORD !== 8'h33) begin
            errors++;
            $display("FAIL ovf_reload got v=%b w=%h required 1/33", dut_if.WORD_VALID, dut_if.WORD);
        end
        drive_bit(1'b0, 1'b0);
        checks++;
        if (dut_if.WORD_VALID !== 1'b0) begin errors++; $display("FAIL ovf_drain_valid got %b required 0", dut_if.WORD_VALID); end
        checks++;
        if (OVERFLOW !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b required 1", OVERFLOW); end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL ovf_drain got %0d left required 0", exp_q.size()); end
    endtask

    task automatic test_sync_loss;
        logic [7:0] z;
        dut_if.WORD_READY = 1'b1;
        do_reset(1);
        z = 8'h00;
        send_byte(8'hB8, 1'b0);
        send_frame(8'h10);
        send_byte(z, 1'b0);
        checks++;
        if (LOCK !== 1'b1 || DBG_STATE !== ST_DATA) begin
            errors++;
            $display("FAIL loss_miss1 got lock=%b st=%0d required 1/%0d", LOCK, DBG_STATE, ST_DATA);
        end
        send_frame(8'h20);
        send_byte(z, 1'b0);
        checks++;
        if (LOCK !== 1'b1) begin errors++; $display("FAIL loss_miss2 got %b required 1", LOCK); end
        send_frame(8'h30);
        for (int i = 7; i >= 1; i--) drive_bit(z[i], 1'b1);
        checks++;
        if (LOCK !== 1'b1) begin errors++; $display("FAIL loss_miss3_early got %b required 1", LOCK); end
        drive_bit(z[0], 1'b1);
        checks++;
        if (LOCK !== 1'b0 || DBG_STATE !== ST_HUNT) begin
            errors++;
            $display("FAIL loss_miss3 got lock=%b st=%0d required 0/%0d", LOCK, DBG_STATE, ST_HUNT);
        end
        drive_bit(1'b0, 1'b0);
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL loss_drain got %0d left required 0", exp_q.size()); end
    endtask

    task automatic test_miss_recover;
        dut_if.WORD_READY = 1'b1;
        do_reset(1);
        send_byte(8'hB8, 1'b0);
        send_frame(8'h40);
        send_byte(8'h00, 1'b0);
        send_frame(8'h50);
        send_byte(8'hB8, 1'b0);
        checks++;
        if (LOCK !== 1'b1 || DBG_STATE !== ST_DATA) begin
            errors++;
            $display("FAIL recover_match got lock=%b st=%0d required 1/%0d", LOCK, DBG_STATE, ST_DATA);
        end
        send_frame(8'h60);
        send_byte(8'h00, 1'b0);
        send_frame(8'h70);
        send_byte(8'h00, 1'b0);
        checks++;
        if (LOCK !== 1'b1) begin errors++; $display("FAIL recover_lock got %b required 1", LOCK); end
        send_frame(8'h80);
        drive_bit(1'b0, 1'b0);
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL recover_drain got %0d left required 0", exp_q.size()); end
    endtask

    // test sequence and final report
    initial begin
        RESET = 1'b1;
        EN = 1'b0;
        D = 1'b0;
        dut_if.WORD_READY = 1'b0;
        test_reset();
        test_reset_mid_word();
        test_stream();
        test_en_toggle();
        test_overflow();
        test_sync_loss();
        test_miss_recover();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
